// File: rtl/conversie_bcd_pkg.sv
// Shared constants for the binary-to-BCD converter: data widths, FSM encodings
// and the per-digit correction rule, reused by the upstream power block and benches.
package conversie_bcd_pkg;

  localparam int W  = 16;
  localparam int ND = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Double-dabble correction: a digit of 5 or more would overflow when doubled.
  localparam logic [3:0] CORR_THRESH = 4'd5;
  localparam logic [3:0] CORR_ADD    = 4'd3;

endpackage

// File: rtl/conversie_bcd_corectie_cifra.sv
// Combinational double-dabble digit correction: adds 3 to a BCD digit that is 5 or more
// so that the following left shift carries correctly into the next decimal digit.
module corectie_cifra
  import conversie_bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= CORR_THRESH) ? (din + CORR_ADD) : din;

endmodule

// File: rtl/conversie_bcd.sv
// Sequential double-dabble converter: one bit per SHIFT cycle, result latched in DONE.
// Conversions are requested by a rising edge on start; only W=16 / ND=5 is supported.
module conversie_bcd #(
  parameter int W  = conversie_bcd_pkg::W,
  parameter int ND = conversie_bcd_pkg::ND
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            start,
  input  logic [W-1:0]    P,
  output logic [4*ND-1:0] BCD,
  output logic            ack,
  output logic            busy
);

  import conversie_bcd_pkg::S_IDLE;
  import conversie_bcd_pkg::S_SHIFT;
  import conversie_bcd_pkg::S_DONE;

  localparam int CW = $clog2(W + 1);

  logic [1:0]      state_reg;
  logic            start_q;
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    bin_reg;
  logic [4*ND-1:0] dig_reg;
  logic [4*ND-1:0] dig_corr;
  logic            start_edge;

  assign start_edge = start & ~start_q;
  assign busy       = (state_reg != S_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_corr
      corectie_cifra u_corr (
        .din  (dig_reg[4*gi +: 4]),
        .dout (dig_corr[4*gi +: 4])
      );
    end
  endgenerate

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= S_IDLE;
      start_q   <= 1'b0;
      cnt_reg   <= '0;
      bin_reg   <= '0;
      dig_reg   <= '0;
      BCD       <= '0;
      ack       <= 1'b0;
    end else begin
      start_q <= start;
      case (state_reg)
        S_IDLE: begin
          if (start_edge) begin
            bin_reg   <= P;
            dig_reg   <= '0;
            cnt_reg   <= CW'(W);
            ack       <= 1'b0;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Correct first, then shift the whole {digits, binary} word one bit left.
          {dig_reg, bin_reg} <= {dig_corr, bin_reg} << 1;
          cnt_reg            <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          BCD       <= dig_reg;
          ack       <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conversie_bcd.sv
// Self-checking bench for conversie_bcd: directed corner cases plus random values,
// compared against a decimal-arithmetic reference model.
module tb_conversie_bcd;
  import conversie_bcd_pkg::*;

  logic            Clk   = 1'b0;
  logic            Rst_n = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    P     = '0;
  logic [4*ND-1:0] BCD;
  logic            ack;
  logic            busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  conversie_bcd #(.W(W), .ND(ND)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .start (start),
    .P     (P),
    .BCD   (BCD),
    .ack   (ack),
    .busy  (busy)
  );

  // Reference: peel decimal digits off with division and remainder.
  function automatic logic [4*ND-1:0] bcd_ref(input int unsigned v);
    logic [4*ND-1:0] r;
    int unsigned     x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Assumes inputs for an accepted conversion are set before the next rising edge.
  // P is scrambled every cycle while busy: the result must not depend on it.
  task automatic wait_ack(input logic [W-1:0] v, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 1) begin
        check({tag, " busy_set"}, 32'(busy), 32'd1);
        check({tag, " ack_clr"}, 32'(ack), 32'd0);
      end
      P = W'($urandom);
    end while (!ack && n < 40);
    check({tag, " latency"}, 32'(n), 32'd18);
    check({tag, " bcd"}, 32'(BCD), 32'(bcd_ref(32'(v))));
    check({tag, " busy_clr"}, 32'(busy), 32'd0);
    $display("conv %s P=%0d BCD=0x%05h edges=%0d", tag, v, BCD, n);
  endtask

  task automatic run_conv(input logic [W-1:0] v, input string tag);
    @(negedge Clk);
    P     = v;
    start = 1'b1;
    wait_ack(v, tag);
    start = 1'b0;
  endtask

  initial begin
    int conv_cnt;
    int rises;
    logic prev_busy;
    logic prev_ack;
    int unsigned pw;

    // Reset state
    #1;
    check("rst bcd", 32'(BCD), 32'd0);
    check("rst ack", 32'(ack), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    #11 Rst_n = 1'b1;

    // Directed values
    run_conv(16'd9, "p9");
    run_conv(16'd65535, "pmax");
    run_conv(16'd0, "pzero");
    run_conv(16'd1000, "p1000");

    // Held start: exactly one conversion
    @(negedge Clk);
    P = 16'd123;
    start = 1'b1;
    conv_cnt = 0;
    prev_busy = busy;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (busy && !prev_busy) conv_cnt++;
      prev_busy = busy;
    end
    check("held count", 32'(conv_cnt), 32'd1);
    check("held bcd", 32'(BCD), 32'(bcd_ref(123)));
    check("held ack", 32'(ack), 32'd1);
    $display("conv held P=123 BCD=0x%05h conversions=%0d", BCD, conv_cnt);
    start = 1'b0;
    run_conv(16'd4567, "reraise");

    // Start edge during SHIFT with P changed: ignored, single ack rise
    @(negedge Clk);
    P = 16'd9;
    start = 1'b1;
    @(negedge Clk);
    prev_ack = ack;
    start = 1'b0;
    P = 16'd81;
    @(negedge Clk);
    start = 1'b1;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (ack && !prev_ack) rises++;
      prev_ack = ack;
    end
    check("midedge rises", 32'(rises), 32'd1);
    check("midedge bcd", 32'(BCD), 32'(bcd_ref(9)));
    check("midedge busy", 32'(busy), 32'd0);
    $display("conv midedge P=9 BCD=0x%05h ack_rises=%0d", BCD, rises);
    start = 1'b0;

    // Reset after the 8th shift, then start held high across reset release
    @(negedge Clk);
    P = 16'd50000;
    start = 1'b1;
    for (int i = 0; i < 9; i++) @(negedge Clk);
    start = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    check("abort ack", 32'(ack), 32'd0);
    check("abort bcd", 32'(BCD), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    $display("conv abort P=50000 BCD=0x%05h ack=%0b", BCD, ack);
    P = 16'd243;
    start = 1'b1;
    #1 Rst_n = 1'b1;
    wait_ack(16'd243, "postrst");
    start = 1'b0;

    // Chained with upstream power block: P = A**B, its ack drives start
    for (int k = 0; k < 2; k++) begin
      int unsigned a;
      int unsigned b;
      a = (k == 0) ? 3 : 2;
      b = (k == 0) ? 2 : 15;
      pw = 1;
      for (int j = 0; j < int'(b); j++) pw = pw * a;
      repeat (3) @(negedge Clk);
      run_conv(W'(pw), (k == 0) ? "pow3_2" : "pow2_15");
    end

    // Random values
    for (int i = 0; i < 20; i++) begin
      run_conv(W'($urandom_range(0, 65535)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conversie_bcd.md
CONVERSIE_BCD -- requirements
Module: conversie_bcd

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning binary input width.
REQ-002 The block SHALL have parameter ND, default 5, meaning BCD output digits; only W=16/ND=5 is supported.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, conversion request; it is level-driven by the upstream ack and rising-edge detected.
REQ-006 The block SHALL have port P, input, W, unsigned binary value, sampled only when a conversion is accepted.
REQ-007 The block SHALL have port BCD, output reg, 4*ND, packed BCD with digit 0 (units) in bits [3:0].
REQ-008 The block SHALL have port ack, output reg, 1, result-valid flag.
REQ-009 The block SHALL have port busy, output, 1, high while the state is not IDLE.

Function
REQ-010 The block SHALL register start into start_q every cycle; an edge is start=1 and start_q=0.
REQ-011 The block SHALL implement states IDLE=0, SHIFT=1, DONE=2; encoding 3 SHALL go to IDLE on the next edge.
REQ-012 In IDLE with an edge, the block SHALL load the shift register with P, clear scratch digits, set cnt=W, clear ack, and go to SHIFT.
REQ-013 In IDLE without an edge, the block SHALL hold all registers and outputs.
REQ-014 Each SHIFT cycle SHALL add 3 to every scratch digit >=5, then shift {digits, bin} left by 1, and decrement cnt.
REQ-015 The block SHALL leave SHIFT for DONE on the edge where cnt goes from 1 to 0, which is the 16th shift.
REQ-016 DONE SHALL copy the scratch digits to BCD, set ack=1, and return to IDLE; it lasts exactly 1 cycle.
REQ-017 Latency SHALL be 18 rising edges from the accepting edge to BCD/ack visible.
REQ-018 BCD SHALL change only in DONE or on reset; it stays stable between conversions.
REQ-019 ack SHALL stay 1 until the next accepted start or reset; the accepting edge clears it.
REQ-020 Start edges during SHIFT or DONE SHALL be ignored and not queued, and P changes there SHALL not affect the result.
REQ-021 A start held high SHALL produce exactly one conversion; a new conversion needs start low for at least 1 cycle.
REQ-022 Every W-bit value SHALL convert exactly (0..65535 -> 0x00000..0x65535), with no overflow possible.

Reset
REQ-023 Rst_n=0 SHALL immediately force state=IDLE, start_q=0, cnt=0, shift/scratch=0, BCD=0, ack=0, busy=0.
REQ-024 Reset mid-conversion SHALL abort it with no partial BCD update.
REQ-025 If start is high on the first edge after Rst_n rises, the block SHALL treat it as an edge and begin a conversion.

Structure
REQ-026 A shared package SHALL hold the state encodings (S_IDLE, S_SHIFT, S_DONE) and constants W=16, ND=5; it SHALL be reused by the upstream power block and the bench.
REQ-027 The design SHALL have one sub-module, corectie_cifra: a combinational 4-bit in/out block that adds 3 when the input is >=5, instantiated ND times.
REQ-028 The state machine, counter, and edge detector SHALL stay in conversie_bcd.

Verification
REQ-029 P=9 with a start edge -> ack=1 and BCD=0x00009 after 18 edges, with busy high in between.
REQ-030 P=65535 -> BCD=0x65535; P=0 -> 0x00000; P=1000 -> 0x01000.
REQ-031 start held high 60 cycles -> exactly one conversion; start dropped then raised -> second conversion, and ack drops on the accepting edge.
REQ-032 Rst_n pulsed low after the 8th shift -> ack=0, BCD=0, state IDLE without waiting for a clock; the next conversion of P=243 gives 0x00243.
REQ-033 Second start edge during SHIFT with P changed 9 -> 81 -> result 0x00009 only, with one ack rise.
REQ-034 Chained with the upstream power block, A=3, B=2, its ack driving start -> BCD=0x00009; A=2, B=15 -> 0x32768.
